servo_sweep_multi: RTL and testbench

- Multi-channel hobby-servo PWM controller; parametrised successor to the single-channel sweep test top.
- One shared frame counter drives N_CH pulse outputs with optional per-channel phase stagger.
- Each channel runs in one of three modes: hold, autonomous sweep, or slew-to-target.
- Sits between board-level control logic (target writes, mode select) and the servo pins.

---
 rtl/servo_sweep_multi.sv | 160 ++++++++++++++++
 tb/tb_servo_sweep_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep_multi.sv
// Multi-channel hobby-servo PWM controller: one shared frame counter, per-channel
// hold / sweep / slew-to-target duty control with optional pulse-start stagger.
module servo_sweep_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned W             = 20,
    parameter int unsigned PERIOD_TICKS  = 500000,
    parameter int unsigned MIN_TICKS     = 25000,
    parameter int unsigned MAX_TICKS     = 50000,
    parameter int unsigned CENTER_TICKS  = 37500,
    parameter int unsigned STEP_TICKS    = 250,
    parameter int unsigned STAGGER_TICKS = 0,
    parameter int unsigned DIV_W         = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [2*N_CH-1:0]   mode_i,
    input  logic [DIV_W-1:0]    speed_div_i,
    input  logic                wr_en_i,
    input  logic [2:0]          wr_ch_i,
    input  logic [W-1:0]        wr_target_i,
    output logic [N_CH-1:0]     pwm_out_o,
    output logic                frame_tick_o,
    output logic [N_CH-1:0]     dir_o,
    output logic [N_CH-1:0]     at_target_o,
    output logic [W*N_CH-1:0]   duty_mon_o
);

    localparam logic [W-1:0] LastCnt = W'(PERIOD_TICKS - 1);
    localparam logic [W-1:0] MinW    = W'(MIN_TICKS);
    localparam logic [W-1:0] MaxW    = W'(MAX_TICKS);
    localparam logic [W-1:0] CenterW = W'(CENTER_TICKS);
    localparam logic [W:0]   MinW1   = (W+1)'(MIN_TICKS);
    localparam logic [W:0]   MaxW1   = (W+1)'(MAX_TICKS);
    localparam logic [W:0]   StepW1  = (W+1)'(STEP_TICKS);

    logic [W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [W-1:0]     duty_q [N_CH];
    logic [W-1:0]     duty_d [N_CH];
    logic [W-1:0]     target_q [N_CH];
    logic [W-1:0]     target_d [N_CH];
    logic [W:0]       inc_sum [N_CH];
    logic [W:0]       dec_diff [N_CH];
    logic [W:0]       off_lo [N_CH];
    logic [N_CH-1:0]  dir_q, dir_d;
    logic [N_CH-1:0]  pwm_q, pwm_d;
    logic [N_CH-1:0]  at_q, at_d;
    logic             last_tick;
    logic             update;
    logic [W-1:0]     wr_clamped;

    always_comb begin
        last_tick   = (frame_cnt_q == LastCnt);
        frame_cnt_d = last_tick ? '0 : frame_cnt_q + W'(1);
        div_cnt_d   = div_cnt_q;
        update      = 1'b0;
        if (last_tick) begin
            if (div_cnt_q == speed_div_i) begin
                div_cnt_d = '0;
                update    = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        if (wr_target_i < MinW) begin
            wr_clamped = MinW;
        end else if (wr_target_i > MaxW) begin
            wr_clamped = MaxW;
        end else begin
            wr_clamped = wr_target_i;
        end
    end

    // Sums are W+1 bits so neither limit can be crossed by wrap-around.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            inc_sum[i]  = {1'b0, duty_q[i]} + StepW1;
            dec_diff[i] = ({1'b0, duty_q[i]} >= StepW1) ? ({1'b0, duty_q[i]} - StepW1) : '0;
            off_lo[i]   = (W+1)'(i * STAGGER_TICKS);
            duty_d[i]   = duty_q[i];
            dir_d[i]    = dir_q[i];
            target_d[i] = target_q[i];

            if (wr_en_i && (wr_ch_i == 3'(i))) begin
                target_d[i] = wr_clamped;
            end

            // Slew compares against target_q, so a coinciding write is seen next update.
            if (update && enable_i) begin
                case (mode_i[2*i +: 2])
                    2'b01: begin
                        if (!dir_q[i]) begin
                            duty_d[i] = (inc_sum[i] >= MaxW1) ? MaxW : inc_sum[i][W-1:0];
                            dir_d[i]  = (duty_d[i] == MaxW);
                        end else begin
                            duty_d[i] = (dec_diff[i] <= MinW1) ? MinW : dec_diff[i][W-1:0];
                            dir_d[i]  = (duty_d[i] != MinW);
                        end
                    end
                    2'b10: begin
                        if (duty_q[i] < target_q[i]) begin
                            duty_d[i] = (inc_sum[i] >= {1'b0, target_q[i]}) ?
                                        target_q[i] : inc_sum[i][W-1:0];
                            dir_d[i]  = 1'b0;
                        end else if (duty_q[i] > target_q[i]) begin
                            duty_d[i] = (dec_diff[i] <= {1'b0, target_q[i]}) ?
                                        target_q[i] : dec_diff[i][W-1:0];
                            dir_d[i]  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            at_d[i]  = (duty_d[i] == target_d[i]);
            pwm_d[i] = enable_i && ({1'b0, frame_cnt_q} >= off_lo[i]) &&
                       ({1'b0, frame_cnt_q} < off_lo[i] + {1'b0, duty_q[i]});
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            div_cnt_q   <= '0;
            dir_q       <= '0;
            pwm_q       <= '0;
            at_q        <= '1;
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i]   <= CenterW;
                target_q[i] <= CenterW;
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            div_cnt_q   <= div_cnt_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            at_q        <= at_d;
            for (int i = 0; i < N_CH; i++) begin
                duty_q[i]   <= duty_d[i];
                target_q[i] <= target_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            duty_mon_o[i*W +: W] = duty_q[i];
        end
    end

    assign frame_tick_o = last_tick;
    assign pwm_out_o    = pwm_q;
    assign dir_o        = dir_q;
    assign at_target_o  = at_q;

endmodule

// File: tb/tb_servo_sweep_multi.sv
// Self-checking bench for servo_sweep_multi: small-frame configuration, expected
// per-update channel state queued with the stimulus and checked after each update.
module tb_servo_sweep_multi;

    localparam int unsigned N_CH = 2;
    localparam int unsigned W    = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [3:0]        mode;
    logic [7:0]        speed_div;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic [W-1:0]      wr_target;
    logic [1:0]        pwm;
    logic              ft;
    logic [1:0]        dir;
    logic [1:0]        at;
    logic [2*W-1:0]    duty_mon;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int d0;
        int d1;
        int dir;
        int at;
    } exp_t;
    exp_t sbq[$];

    servo_sweep_multi #(
        .N_CH(2), .W(20), .PERIOD_TICKS(1000), .MIN_TICKS(50), .MAX_TICKS(100),
        .CENTER_TICKS(75), .STEP_TICKS(10), .STAGGER_TICKS(200), .DIV_W(8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .mode_i      (mode),
        .speed_div_i (speed_div),
        .wr_en_i     (wr_en),
        .wr_ch_i     (wr_ch),
        .wr_target_i (wr_target),
        .pwm_out_o   (pwm),
        .frame_tick_o(ft),
        .dir_o       (dir),
        .at_target_o (at),
        .duty_mon_o  (duty_mon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int d0, input int d1, input int dr, input int a);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.dir = dr; e.at = a;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input string tag, output int ed0, output int ed1);
        exp_t e;
        ed0 = 0; ed1 = 0;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            ed0 = e.d0; ed1 = e.d1;
            chk({tag, "_d0"}, 32'(duty_mon[W-1:0]), e.d0);
            chk({tag, "_d1"}, 32'(duty_mon[2*W-1:W]), e.d1);
            chk({tag, "_dir"}, 32'(dir), e.dir);
            chk({tag, "_at"}, 32'(at), e.at);
        end
    endtask

    // Returns at the negedge right after the update edge (frame_cnt == 0).
    task automatic next_update();
        int n = 0;
        while (ft !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1100) chk("tick_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic measure(output int w0, output int w1);
        w0 = 0; w1 = 0;
        repeat (999) begin
            @(negedge clk);
            if (pwm[0] === 1'b1) w0++;
            if (pwm[1] === 1'b1) w1++;
        end
    endtask

    task automatic upd_check(input string tag);
        int a, b;
        next_update();
        pop_check(tag, a, b);
    endtask

    initial begin
        int perr, ferr, fcnt, m, n, w0, w1, e0, e1;
        rst_n = 1'b0; enable = 1'b1; mode = 4'b0000; speed_div = 8'd0;
        wr_en = 1'b0; wr_ch = 3'd0; wr_target = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_ft", 32'(ft), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_at", 32'(at), 3);
        chk("rst_d0", 32'(duty_mon[W-1:0]), 75);
        chk("rst_d1", 32'(duty_mon[2*W-1:W]), 75);
        rst_n = 1'b1;

        // Hold mode: two full frames of pulse pattern and frame_tick timing.
        perr = 0; ferr = 0; fcnt = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            m = (k - 1) % 1000;
            if (pwm[0] !== (m < 75)) perr++;
            if (pwm[1] !== (m >= 200 && m < 275)) perr++;
            if (ft !== ((k % 1000) == 999)) ferr++;
            if (ft === 1'b1) fcnt++;
        end
        chk("hold_pwm_errs", perr, 0);
        chk("ft_errs", ferr, 0);
        chk("ft_count", fcnt, 2);

        // ch0 sweep, update every frame.
        mode = 4'b0001;
        push(85, 75, 0, 2); push(95, 75, 0, 2); push(100, 75, 1, 2);
        push(90, 75, 1, 2); push(80, 75, 1, 2); push(70, 75, 1, 2);
        push(60, 75, 1, 2); push(50, 75, 0, 2); push(60, 75, 0, 2);
        for (int k = 0; k < 9; k++) upd_check("sweep");

        // Divided updates; pulse width must match the duty of each frame.
        speed_div = 8'd2;
        push(60, 75, 0, 2); push(60, 75, 0, 2); push(70, 75, 0, 2);
        push(70, 75, 0, 2); push(70, 75, 0, 2); push(80, 75, 0, 2);
        for (int k = 0; k < 6; k++) begin
            next_update();
            pop_check("div", e0, e1);
            measure(w0, w1);
            chk("div_w0", w0, e0);
            chk("div_w1", w1, e1);
        end

        // ch1 slew toward 92, then toward clamped 50.
        speed_div = 8'd0;
        mode = 4'b1000;
        wr_en = 1'b1; wr_ch = 3'd1; wr_target = 20'd92;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr92_at", 32'(at), 0);
        push(80, 85, 0, 0); push(80, 92, 0, 2); push(80, 92, 0, 2);
        for (int k = 0; k < 3; k++) upd_check("slew_up");
        wr_en = 1'b1; wr_ch = 3'd1; wr_target = 20'd10;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr10_at", 32'(at), 0);
        push(80, 82, 2, 0); push(80, 72, 2, 0); push(80, 62, 2, 0);
        push(80, 52, 2, 0); push(80, 50, 2, 2);
        for (int k = 0; k < 5; k++) upd_check("slew_dn");

        // Write coinciding with the update edge: that update uses the old target.
        n = 0;
        while (ft !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1100) chk("coin_timeout", 1, 0);
        wr_en = 1'b1; wr_ch = 3'd1; wr_target = 20'd100;
        @(negedge clk);
        wr_en = 1'b0;
        push(80, 50, 2, 0);
        pop_check("coin", e0, e1);
        push(80, 60, 0, 0);
        upd_check("coin_next");

        // Out-of-range channel write is ignored.
        wr_en = 1'b1; wr_ch = 3'd5; wr_target = 20'd70;
        @(negedge clk);
        wr_en = 1'b0;
        chk("badch_at", 32'(at), 0);
        push(80, 70, 0, 0); push(80, 80, 0, 0);
        for (int k = 0; k < 2; k++) upd_check("badch");

        // Asynchronous reset in the middle of a ch1 pulse.
        n = 0;
        while (pwm[1] !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_seen", 32'(n < 1100), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm), 0);
        chk("arst_d0", 32'(duty_mon[W-1:0]), 75);
        chk("arst_d1", 32'(duty_mon[2*W-1:W]), 75);
        chk("arst_dir", 32'(dir), 0);
        chk("arst_at", 32'(at), 3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pwm", 32'(pwm), 1);

        // Disable mid-frame: outputs drop next cycle, duty frozen for 3 frames.
        mode = 4'b0001;
        push(85, 75, 0, 2);
        upd_check("en_pre");
        repeat (30) @(negedge clk);
        chk("pre_dis_pwm", 32'(pwm), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_pwm", 32'(pwm), 0);
        for (int k = 0; k < 3; k++) begin
            push(85, 75, 0, 2);
            next_update();
            pop_check("dis", e0, e1);
            measure(w0, w1);
            chk("dis_w0", w0, 0);
            chk("dis_w1", w1, 0);
        end
        enable = 1'b1;
        push(95, 75, 0, 2);
        next_update();
        pop_check("reen", e0, e1);
        measure(w0, w1);
        chk("reen_w0", w0, e0);
        chk("reen_w1", w1, e1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
